// File: rtl/core_result_collector_if.sv
// Run-control and result bus between the prime-search top level and the
// result collector. The master drives start/enable/strobes/results; the slave reports.
interface core_result_collector_if #(
  parameter int CORES    = 4,
  parameter int RESULT_W = 8,
  parameter int CYCLE_W  = 16,
  parameter int SUM_W    = 11,
  parameter int SEL_W    = 3
);
  logic                      start;
  logic [CORES-1:0]          core_enable;
  logic [CORES-1:0]          done_strobe;
  logic [CORES*RESULT_W-1:0] result;
  logic [SEL_W-1:0]          rd_sel;
  logic                      busy;
  logic                      all_done;
  logic                      timeout;
  logic [CORES-1:0]          done_vec;
  logic [CYCLE_W-1:0]        run_cycles;
  logic [SUM_W-1:0]          total_sum;
  logic                      sum_valid;
  logic [CYCLE_W-1:0]        rd_cycles;

  modport master (
    output start, core_enable, done_strobe, result, rd_sel,
    input  busy, all_done, timeout, done_vec, run_cycles, total_sum, sum_valid, rd_cycles
  );

  modport slave (
    input  start, core_enable, done_strobe, result, rd_sel,
    output busy, all_done, timeout, done_vec, run_cycles, total_sum, sum_valid, rd_cycles
  );
endinterface

// File: rtl/core_result_collector.sv
// Completion monitor for the prime-search cores: detects each core's strobe
// falling edge, latches its result and finish cycle, and aggregates the run.
module core_result_collector #(
  parameter int CORES    = 4,
  parameter int RESULT_W = 8,
  parameter int CYCLE_W  = 16,
  parameter int SUM_W    = 11,
  parameter int SEL_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  core_result_collector_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CYCLE_W-1:0] CYC_MAX = '1;

  logic [1:0]          state_q, state_d;
  logic [CORES-1:0]    en_q, en_d;
  logic [CORES-1:0]    done_vec_q, done_vec_d;
  logic [CORES-1:0]    prev_strobe_q, prev_strobe_d;
  logic [CORES-1:0]    cap;
  logic [CYCLE_W-1:0]  run_cycles_q, run_cycles_d, run_next;
  logic [RESULT_W-1:0] res_q [CORES];
  logic [RESULT_W-1:0] res_d [CORES];
  logic [CYCLE_W-1:0]  fin_q [CORES];
  logic [CYCLE_W-1:0]  fin_d [CORES];
  logic                timeout_q, timeout_d;
  logic                sum_valid_q, sum_valid_d;
  logic [SUM_W-1:0]    total_sum_q, total_sum_d;
  logic [CYCLE_W-1:0]  rd_cycles_c;

  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    done_vec_d    = done_vec_q;
    run_cycles_d  = run_cycles_q;
    res_d         = res_q;
    fin_d         = fin_q;
    timeout_d     = timeout_q;
    sum_valid_d   = sum_valid_q;
    // Sampled in every state so a strobe already low at start never reads as an edge.
    prev_strobe_d = bus.done_strobe;
    run_next      = run_cycles_q + CYCLE_W'(1);
    cap           = prev_strobe_q & ~bus.done_strobe & en_q & ~done_vec_q;

    case (state_q)
      S_RUN: begin
        run_cycles_d = run_next;
        done_vec_d   = done_vec_q | cap;
        for (int i = 0; i < CORES; i++) begin
          if (cap[i]) begin
            res_d[i] = bus.result[i*RESULT_W +: RESULT_W];
            fin_d[i] = run_next;
          end
        end
        // Completion takes priority over counter saturation on the same edge.
        if ((done_vec_d & en_q) == en_q) begin
          state_d = S_DONE;
        end else if (run_next == CYC_MAX) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        if (state_q == S_DONE) sum_valid_d = 1'b1;
        if (bus.start) begin
          en_d         = bus.core_enable;
          done_vec_d   = '0;
          run_cycles_d = '0;
          res_d        = '{default: '0};
          fin_d        = '{default: '0};
          timeout_d    = 1'b0;
          sum_valid_d  = 1'b0;
          state_d      = (bus.core_enable == '0) ? S_DONE : S_RUN;
        end
      end
    endcase
  end

  always_comb begin
    total_sum_d = '0;
    for (int i = 0; i < CORES; i++) begin
      if (done_vec_q[i] && en_q[i]) total_sum_d = total_sum_d + SUM_W'(res_q[i]);
    end
  end

  always_comb begin
    rd_cycles_c = '0;
    for (int i = 0; i < CORES; i++) begin
      if (bus.rd_sel == SEL_W'(i)) rd_cycles_c = fin_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      en_q          <= '0;
      done_vec_q    <= '0;
      prev_strobe_q <= '0;
      run_cycles_q  <= '0;
      res_q         <= '{default: '0};
      fin_q         <= '{default: '0};
      timeout_q     <= 1'b0;
      sum_valid_q   <= 1'b0;
      total_sum_q   <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      done_vec_q    <= done_vec_d;
      prev_strobe_q <= prev_strobe_d;
      run_cycles_q  <= run_cycles_d;
      res_q         <= res_d;
      fin_q         <= fin_d;
      timeout_q     <= timeout_d;
      sum_valid_q   <= sum_valid_d;
      total_sum_q   <= total_sum_d;
    end
  end

  assign bus.busy       = (state_q == S_RUN);
  assign bus.all_done   = (state_q == S_DONE);
  assign bus.timeout    = timeout_q;
  assign bus.done_vec   = done_vec_q;
  assign bus.run_cycles = run_cycles_q;
  assign bus.total_sum  = total_sum_q;
  assign bus.sum_valid  = sum_valid_q;
  assign bus.rd_cycles  = rd_cycles_c;

endmodule

// File: tb/tb_core_result_collector.sv
// Scoreboard bench for core_result_collector: a 16-bit-counter instance for the
// functional runs and a 4-bit-counter instance for saturation behaviour.
module tb_core_result_collector;

  localparam int CORES = 4, RESULT_W = 8, CYCLE_W = 16, SUM_W = 11, SEL_W = 3;
  localparam int NEVER = -100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  core_enable = '0;
  logic [3:0]  strobe = '1;
  logic [31:0] result = '0;
  logic [2:0]  rd_sel = '0;

  always #5 clk = ~clk;

  core_result_collector_if #(.CORES(CORES), .RESULT_W(RESULT_W), .CYCLE_W(CYCLE_W),
                             .SUM_W(SUM_W), .SEL_W(SEL_W)) bus ();
  core_result_collector_if #(.CORES(CORES), .RESULT_W(RESULT_W), .CYCLE_W(4),
                             .SUM_W(SUM_W), .SEL_W(SEL_W)) bus_t ();

  assign bus.start = start;         assign bus_t.start = start;
  assign bus.core_enable = core_enable; assign bus_t.core_enable = core_enable;
  assign bus.done_strobe = strobe;  assign bus_t.done_strobe = strobe;
  assign bus.result = result;       assign bus_t.result = result;
  assign bus.rd_sel = rd_sel;       assign bus_t.rd_sel = rd_sel;

  core_result_collector #(.CORES(CORES), .RESULT_W(RESULT_W), .CYCLE_W(CYCLE_W),
                          .SUM_W(SUM_W), .SEL_W(SEL_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  core_result_collector #(.CORES(CORES), .RESULT_W(RESULT_W), .CYCLE_W(4),
                          .SUM_W(SUM_W), .SEL_W(SEL_W))
    dut_t (.clk(clk), .reset(reset), .bus(bus_t));

  typedef struct {
    logic [3:0]  dv;
    logic [15:0] rc;
    logic [10:0] sum;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Strobe schedule: a core is low only at edge fall1/fall2, or while k < hold_until if held.
  int          fall1 [4];
  int          fall2 [4];
  logic [3:0]  hold_low;
  int          hold_until;
  int          swap_at;
  logic [31:0] result_late;
  int          mid_start;

  task automatic clear_sched();
    for (int i = 0; i < 4; i++) begin
      fall1[i] = NEVER;
      fall2[i] = NEVER;
    end
    hold_low = '0; hold_until = 0; swap_at = 0; result_late = '0; mid_start = 0;
  endtask

  task automatic set_inputs(input int k);
    for (int i = 0; i < 4; i++)
      strobe[i] = !((hold_low[i] && k < hold_until) || k == fall1[i] || k == fall2[i]);
    if (swap_at != 0 && k >= swap_at) result = result_late;
    if (k > 0) start = (k == mid_start);
  endtask

  task automatic step(input int k);
    set_inputs(k);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(0);
  endtask

  task automatic run_until(input bit on_t, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 1; k <= budget && !ok; k++) begin
      step(k);
      ok = on_t ? bus_t.all_done : bus.all_done;
    end
  endtask

  function automatic logic [10:0] model_sum(input logic [3:0] mask, input logic [31:0] r);
    logic [10:0] s = '0;
    for (int i = 0; i < 4; i++) if (mask[i]) s = s + {3'b0, r[i*8 +: 8]};
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      strobe = ~strobe;
      @(posedge clk); #1;
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.all_done !== 1'b0) begin errors++; $display("FAIL reset_all_done got=%0b exp=0", bus.all_done); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%0b exp=0", bus.timeout); end
    checks++; if (bus.done_vec !== 4'b0) begin errors++; $display("FAIL reset_done_vec got=%b exp=0000", bus.done_vec); end
    checks++; if (bus.run_cycles !== 16'd0) begin errors++; $display("FAIL reset_run_cycles got=%0d exp=0", bus.run_cycles); end
    checks++; if (bus.total_sum !== 11'd0 || bus.sum_valid !== 1'b0) begin errors++;
      $display("FAIL reset_sum got=%0d/%0b exp=0/0", bus.total_sum, bus.sum_valid); end
    checks++; if (bus.rd_cycles !== 16'd0) begin errors++; $display("FAIL reset_rd_cycles got=%0d exp=0", bus.rd_cycles); end
    strobe = '1;
    reset = 1'b1;
    step(-1);
  endtask

  task automatic test_staggered();
    exp_t e;
    bit ok;
    clear_sched();
    core_enable = 4'b1111;
    result = {8'd14, 8'd13, 8'd14, 8'd13};
    fall1[0] = 100; fall1[1] = 200; fall1[2] = 300; fall1[3] = 400;
    sb.push_back('{dv: 4'b1111, rc: 16'd400, sum: model_sum(4'b1111, result), to: 1'b0});
    pulse_start();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stag_busy got=%0b exp=1", bus.busy); end
    run_until(1'b0, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stag_done_wait got=0 exp=1"); end
    e = sb.pop_front();
    checks++; if (bus.done_vec !== e.dv || bus.run_cycles !== e.rc || bus.timeout !== e.to || bus.busy !== 1'b0) begin errors++;
      $display("FAIL stag_final got=%b/%0d/%0b exp=%b/%0d/%0b", bus.done_vec, bus.run_cycles, bus.timeout, e.dv, e.rc, e.to); end
    step(1000);
    checks++; if (bus.total_sum !== e.sum || bus.sum_valid !== 1'b1) begin errors++;
      $display("FAIL stag_sum got=%0d/%0b exp=%0d/1", bus.total_sum, bus.sum_valid, e.sum); end
    rd_sel = 3'd2; #1;
    checks++; if (bus.rd_cycles !== 16'd300) begin errors++; $display("FAIL stag_rd2 got=%0d exp=300", bus.rd_cycles); end
    rd_sel = 3'd0; #1;
    checks++; if (bus.rd_cycles !== 16'd100) begin errors++; $display("FAIL stag_rd0 got=%0d exp=100", bus.rd_cycles); end
    rd_sel = 3'd5; #1;
    checks++; if (bus.rd_cycles !== 16'd0) begin errors++; $display("FAIL stag_rd5 got=%0d exp=0", bus.rd_cycles); end
    rd_sel = 3'd0;
  endtask

  task automatic test_partial();
    exp_t e;
    bit ok;
    clear_sched();
    core_enable = 4'b0101;
    result = 32'h00_07_03_05;
    result_late = 32'h00_07_03_2A;
    swap_at = 12;
    fall1[0] = 10; fall2[0] = 15; fall1[1] = 5; fall1[2] = 20;
    sb.push_back('{dv: 4'b0101, rc: 16'd20, sum: model_sum(4'b0101, 32'h00_07_03_05), to: 1'b0});
    pulse_start();
    run_until(1'b0, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL part_done_wait got=0 exp=1"); end
    e = sb.pop_front();
    checks++; if (bus.done_vec !== e.dv || bus.run_cycles !== e.rc) begin errors++;
      $display("FAIL part_final got=%b/%0d exp=%b/%0d", bus.done_vec, bus.run_cycles, e.dv, e.rc); end
    step(1000);
    checks++; if (bus.total_sum !== e.sum) begin errors++; $display("FAIL part_sum got=%0d exp=%0d", bus.total_sum, e.sum); end
    rd_sel = 3'd0; #1;
    checks++; if (bus.rd_cycles !== 16'd10) begin errors++; $display("FAIL part_rd0 got=%0d exp=10", bus.rd_cycles); end
    rd_sel = 3'd1; #1;
    checks++; if (bus.rd_cycles !== 16'd0) begin errors++; $display("FAIL part_rd1 got=%0d exp=0", bus.rd_cycles); end
    rd_sel = 3'd0;
  endtask

  task automatic test_simul_stale();
    exp_t e;
    bit ok;
    clear_sched();
    core_enable = 4'b1111;
    result = 32'h04_03_02_01;
    hold_low = 4'b0010; hold_until = 20;
    fall1[0] = 8; fall1[3] = 8; fall1[2] = 12; fall1[1] = 30;
    sb.push_back('{dv: 4'b1111, rc: 16'd30, sum: model_sum(4'b1111, result), to: 1'b0});
    step(-1);
    pulse_start();
    run_until(1'b0, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL simul_done_wait got=0 exp=1"); end
    e = sb.pop_front();
    checks++; if (bus.done_vec !== e.dv || bus.run_cycles !== e.rc) begin errors++;
      $display("FAIL simul_final got=%b/%0d exp=%b/%0d", bus.done_vec, bus.run_cycles, e.dv, e.rc); end
    step(1000);
    checks++; if (bus.total_sum !== e.sum) begin errors++; $display("FAIL simul_sum got=%0d exp=%0d", bus.total_sum, e.sum); end
    rd_sel = 3'd3; #1;
    checks++; if (bus.rd_cycles !== 16'd8) begin errors++; $display("FAIL simul_rd3 got=%0d exp=8", bus.rd_cycles); end
    rd_sel = 3'd1; #1;
    checks++; if (bus.rd_cycles !== 16'd30) begin errors++; $display("FAIL stale_rd1 got=%0d exp=30", bus.rd_cycles); end
    rd_sel = 3'd0;
  endtask

  task automatic test_timeout();
    exp_t e;
    bit ok;
    clear_sched();
    core_enable = 4'b0001;
    result = 32'h00_00_00_09;
    sb.push_back('{dv: 4'b0000, rc: 16'd15, sum: 11'd0, to: 1'b1});
    pulse_start();
    run_until(1'b1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_done_wait got=0 exp=1"); end
    e = sb.pop_front();
    checks++; if (bus_t.done_vec !== e.dv || {12'd0, bus_t.run_cycles} !== e.rc || bus_t.timeout !== e.to) begin errors++;
      $display("FAIL tmo_final got=%b/%0d/%0b exp=%b/%0d/%0b", bus_t.done_vec, bus_t.run_cycles, bus_t.timeout, e.dv, e.rc, e.to); end
    step(1000);
    checks++; if (bus_t.sum_valid !== 1'b1 || bus_t.total_sum !== e.sum) begin errors++;
      $display("FAIL tmo_sum got=%0d/%0b exp=%0d/1", bus_t.total_sum, bus_t.sum_valid, e.sum); end
    fall1[0] = 15;
    sb.push_back('{dv: 4'b0001, rc: 16'd15, sum: 11'd9, to: 1'b0});
    pulse_start();
    run_until(1'b1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_edge_wait got=0 exp=1"); end
    e = sb.pop_front();
    checks++; if (bus_t.done_vec !== e.dv || {12'd0, bus_t.run_cycles} !== e.rc || bus_t.timeout !== e.to) begin errors++;
      $display("FAIL tmo_edge_final got=%b/%0d/%0b exp=%b/%0d/%0b", bus_t.done_vec, bus_t.run_cycles, bus_t.timeout, e.dv, e.rc, e.to); end
    step(1000);
    checks++; if (bus_t.total_sum !== e.sum) begin errors++; $display("FAIL tmo_edge_sum got=%0d exp=%0d", bus_t.total_sum, e.sum); end
  endtask

  task automatic test_restart_disrupt();
    exp_t e;
    bit ok;
    reset = 1'b0; step(-1); reset = 1'b1;
    clear_sched();
    core_enable = 4'b0011;
    result = 32'h00_00_21_11;
    fall1[0] = 5; fall1[1] = 7; mid_start = 3;
    sb.push_back('{dv: 4'b0011, rc: 16'd7, sum: model_sum(4'b0011, result), to: 1'b0});
    pulse_start();
    run_until(1'b0, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midstart_done_wait got=0 exp=1"); end
    e = sb.pop_front();
    checks++; if (bus.done_vec !== e.dv || bus.run_cycles !== e.rc) begin errors++;
      $display("FAIL midstart_final got=%b/%0d exp=%b/%0d", bus.done_vec, bus.run_cycles, e.dv, e.rc); end
    step(1000);
    checks++; if (bus.total_sum !== e.sum) begin errors++; $display("FAIL midstart_sum got=%0d exp=%0d", bus.total_sum, e.sum); end

    clear_sched();
    core_enable = 4'b0100;
    fall1[2] = 9;
    sb.push_back('{dv: 4'b0100, rc: 16'd9, sum: 11'd0, to: 1'b0});
    pulse_start();
    checks++; if (bus.busy !== 1'b1 || bus.done_vec !== 4'b0 || bus.run_cycles !== 16'd0 ||
                   bus.sum_valid !== 1'b0 || bus.rd_cycles !== 16'd0) begin errors++;
      $display("FAIL restart_clear got=%0b/%b/%0d/%0b/%0d exp=1/0000/0/0/0", bus.busy, bus.done_vec,
               bus.run_cycles, bus.sum_valid, bus.rd_cycles); end
    run_until(1'b0, 40, ok);
    e = sb.pop_front();
    checks++; if (!ok || bus.done_vec !== e.dv || bus.run_cycles !== e.rc) begin errors++;
      $display("FAIL restart_final got=%b/%0d exp=%b/%0d", bus.done_vec, bus.run_cycles, e.dv, e.rc); end

    clear_sched();
    core_enable = 4'b1111;
    fall1[0] = 2;
    pulse_start();
    step(1); step(2); step(3);
    reset = 1'b0;
    step(4);
    checks++; if (bus.busy !== 1'b0 || bus.all_done !== 1'b0 || bus.done_vec !== 4'b0 || bus.run_cycles !== 16'd0) begin errors++;
      $display("FAIL midreset got=%0b/%0b/%b/%0d exp=0/0/0000/0", bus.busy, bus.all_done, bus.done_vec, bus.run_cycles); end
    reset = 1'b1;
    step(5);

    clear_sched();
    core_enable = 4'b0000;
    pulse_start();
    checks++; if (bus.all_done !== 1'b1 || bus.busy !== 1'b0 || bus.run_cycles !== 16'd0) begin errors++;
      $display("FAIL zero_en got=%0b/%0b/%0d exp=1/0/0", bus.all_done, bus.busy, bus.run_cycles); end
    step(1000);
    checks++; if (bus.sum_valid !== 1'b1 || bus.total_sum !== 11'd0) begin errors++;
      $display("FAIL zero_en_sum got=%0d/%0b exp=0/1", bus.total_sum, bus.sum_valid); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    clear_sched();
    test_reset();
    test_staggered();
    test_partial();
    test_simul_stale();
    test_timeout();
    test_restart_disrupt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
